// File: rtl/adc_serial_responder.sv
// Slave end of a cs_n/adclk/sdo serial ADC link; pin-to-sdo latency is 3 clk cycles.
// Define ADC_RESP_RAMP_EN to send an incrementing ramp instead of the sample holding register.
module adc_serial_responder #(
  parameter int DATA_W    = 16,
  parameter int LEAD_CLKS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              adclk,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sdo,
  output logic              sdo_oe,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              stale
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TAIL} state_t;

  state_t            state, state_n;
  logic [2:0]        cs_sync, ad_sync;
  logic              cs_fall, cs_rise, ad_fall;
  logic [DATA_W-1:0] shreg, shreg_n, load_val;
  logic [CNT_W-1:0]  bit_cnt, bit_n;
  logic [2:0]        lead_cnt, lead_n;
  logic              sdo_n, oe_n, done_n, abort_n, stale_n;
  logic              fresh, fresh_n;

  // [0],[1] are the synchroniser pair, [2] is the delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync <= 3'b111;
      ad_sync <= 3'b111;
    end else begin
      cs_sync <= {cs_sync[1:0], cs_n};
      ad_sync <= {ad_sync[1:0], adclk};
    end
  end

  assign cs_fall = cs_sync[2] & ~cs_sync[1];
  assign cs_rise = ~cs_sync[2] & cs_sync[1];
  assign ad_fall = ad_sync[2] & ~ad_sync[1];

`ifdef ADC_RESP_RAMP_EN
  logic [DATA_W-1:0] ramp;

  always_ff @(posedge clk) begin
    if (!rst_n)      ramp <= '0;
    else if (done_n) ramp <= ramp + DATA_W'(1);
  end

  assign load_val = ramp;
`else
  logic [DATA_W-1:0] hold;

  always_ff @(posedge clk) begin
    if (!rst_n)            hold <= '0;
    else if (sample_valid) hold <= sample_data;
  end

  // Same-cycle sample_valid bypasses the holding register at frame start
  assign load_val = sample_valid ? sample_data : hold;
`endif

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bit_n   = bit_cnt;
    lead_n  = lead_cnt;
    sdo_n   = sdo;
    oe_n    = sdo_oe;
    done_n  = 1'b0;
    abort_n = 1'b0;
    stale_n = stale;
    fresh_n = fresh | sample_valid;
    case (state)
      IDLE: begin
        sdo_n = 1'b0;
        oe_n  = 1'b0;
        if (cs_fall) begin
          shreg_n = load_val;
          stale_n = ~(fresh | sample_valid);
          fresh_n = 1'b0;
          oe_n    = 1'b1;
          if (LEAD_CLKS > 0) begin
            lead_n  = '0;
            state_n = LEAD;
          end else begin
            sdo_n   = load_val[DATA_W-1];
            bit_n   = '0;
            state_n = SHIFT;
          end
        end
      end
      LEAD: begin
        if (cs_rise) begin
          abort_n = 1'b1;
          sdo_n   = 1'b0;
          oe_n    = 1'b0;
          state_n = IDLE;
        end else if (ad_fall) begin
          lead_n = lead_cnt + 3'd1;
          if (({1'b0, lead_cnt} + 4'd1) == 4'(LEAD_CLKS)) begin
            sdo_n   = shreg[DATA_W-1];
            bit_n   = '0;
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          abort_n = 1'b1;
          sdo_n   = 1'b0;
          oe_n    = 1'b0;
          state_n = IDLE;
        end else if (ad_fall) begin
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            sdo_n   = 1'b0;
            state_n = TAIL;
          end else begin
            shreg_n = {shreg[DATA_W-2:0], 1'b0};
            sdo_n   = shreg[DATA_W-2];
            bit_n   = bit_cnt + CNT_W'(1);
          end
        end
      end
      TAIL: begin
        sdo_n = 1'b0;
        oe_n  = 1'b1;
        if (cs_rise) begin
          done_n  = 1'b1;
          oe_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef ADC_RESP_RAMP_EN
    stale_n = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      lead_cnt    <= '0;
      sdo         <= 1'b0;
      sdo_oe      <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      stale       <= 1'b0;
      fresh       <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      bit_cnt     <= bit_n;
      lead_cnt    <= lead_n;
      sdo         <= sdo_n;
      sdo_oe      <= oe_n;
      frame_done  <= done_n;
      frame_abort <= abort_n;
      stale       <= stale_n;
      fresh       <= fresh_n;
    end
  end

  assign busy = (state != IDLE);

endmodule
